// File: rtl/apb_fir_ctrl.sv
// apb_fir_ctrl: zero-wait APB3 register file that configures and starts the FIR core
module apb_fir_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h20,
    parameter int          WSP_W     = 6,
    parameter int          PROBEK_W  = 14,
    parameter logic [31:0] ID_VALUE  = 32'h4649_5201
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [31:0]         PADDR,
    input  logic                PSELx,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PWDATA,
    output logic                PREADY,
    output logic [31:0]         PRDATA,
    output logic                PSLVERR,
    output logic                Start,
    input  logic                pracuje,
    input  logic                DONE,
    output logic [WSP_W-1:0]    Ile_wsp,
    output logic [PROBEK_W-1:0] Ile_probek
);
    logic [2:0] idx;
    logic       in_win;
    logic       mapped;
    logic       access;
    logic       err;
    logic       wr;
    logic       done_sticky;
    logic       unused_wdata;

    assign idx          = PADDR[2:0];
    assign in_win       = PADDR[31:3] == BASE_ADDR[31:3];
    assign mapped       = idx != 3'd2 && idx != 3'd5 && idx != 3'd6;
    assign access       = PSELx && PENABLE;
    // Geometry registers are frozen while the core is busy or has been told to start.
    assign err          = access && (!in_win || !mapped ||
                          (PWRITE && (idx == 3'd7 ||
                          ((idx == 3'd3 || idx == 3'd4) && (pracuje || Start)))));
    assign wr           = access && PWRITE && !err;
    assign PREADY       = 1'b1;
    assign PSLVERR      = err;
    assign unused_wdata = ^PWDATA;

    // Read mux: only a selected, in-window, mapped read drives data; everything else reads zero.
    always_comb begin
        PRDATA = 32'h0;
        if (PSELx && !PWRITE && in_win)
            PRDATA = idx == 3'd0 ? {31'h0, Start} :
                     idx == 3'd1 ? {29'h0, done_sticky, DONE, pracuje} :
                     idx == 3'd3 ? {{(32-WSP_W){1'b0}}, Ile_wsp} :
                     idx == 3'd4 ? {{(32-PROBEK_W){1'b0}}, Ile_probek} :
                     idx == 3'd7 ? ID_VALUE : 32'h0;
    end

    // Register state: a CTRL write beats the DONE auto-clear, and DONE beats a sticky-bit clear.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            Start       <= 1'b0;
            done_sticky <= 1'b0;
            Ile_wsp     <= '0;
            Ile_probek  <= '0;
        end else begin
            if (wr && idx == 3'd0)
                Start <= PWDATA[0];
            else if (DONE)
                Start <= 1'b0;
            if (DONE)
                done_sticky <= 1'b1;
            else if (wr && idx == 3'd1 && PWDATA[2])
                done_sticky <= 1'b0;
            if (wr && idx == 3'd3)
                Ile_wsp <= PWDATA[WSP_W-1:0];
            if (wr && idx == 3'd4)
                Ile_probek <= PWDATA[PROBEK_W-1:0];
        end
    end
endmodule

// File: tb/tb_apb_fir_ctrl.sv
// tb_apb_fir_ctrl: randomized APB traffic against a behavioural register-file model
module tb_apb_fir_ctrl;
    localparam logic [31:0] ID = 32'h4649_5201;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [31:0] PADDR = 32'h0;
    logic        PSELx = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = 32'h0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic        Start;
    logic        pracuje = 1'b0;
    logic        DONE = 1'b0;
    logic [5:0]  Ile_wsp;
    logic [13:0] Ile_probek;

    int total = 0;
    int bad = 0;

    logic        m_start, m_sticky;
    logic [31:0] m_wsp, m_probek;
    logic        p_valid = 1'b0;
    logic [31:0] p_addr, p_data;

    apb_fir_ctrl dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR), .Start(Start), .pracuje(pracuje), .DONE(DONE),
        .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek)
    );

    always #5 PCLK = ~PCLK;

    // One rising edge, with the model advanced by the register rules for that edge.
    task automatic tick();
        @(posedge PCLK);
        if (PRESET) begin
            m_start = 0; m_sticky = 0; m_wsp = 0; m_probek = 0;
        end else begin
            if (p_valid && p_addr % 8 == 0) m_start = p_data[0];
            else if (DONE) m_start = 0;
            if (DONE) m_sticky = 1;
            else if (p_valid && p_addr % 8 == 1 && p_data[2]) m_sticky = 0;
            if (p_valid && p_addr % 8 == 3) m_wsp = p_data % 64;
            if (p_valid && p_addr % 8 == 4) m_probek = p_data % 16384;
        end
        #1;
    endtask

    function automatic logic exp_err(input logic [31:0] a, input logic w);
        int i = int'(a % 8);
        if (a / 8 != 32'h20 / 8) return 1;
        if (i == 2 || i == 5 || i == 6) return 1;
        if (w && i == 7) return 1;
        if (w && (i == 3 || i == 4) && (pracuje || m_start)) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic w);
        int i = int'(a % 8);
        if (w || a / 8 != 32'h20 / 8) return 0;
        case (i)
            0: return {31'h0, m_start};
            1: return m_sticky * 4 + DONE * 2 + pracuje;
            3: return m_wsp;
            4: return m_probek;
            7: return ID;
            default: return 0;
        endcase
    endfunction

    // Full SETUP+ACCESS transfer; returns what the slave showed during ACCESS.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
        PSELx = 1; PENABLE = 0; PADDR = a; PWRITE = w; PWDATA = d;
        tick();
        PENABLE = 1;
        #2;
        rd = PRDATA; er = PSLVERR;
        p_valid = w && !exp_err(a, w); p_addr = a; p_data = d;
        tick();
        p_valid = 0; PSELx = 0; PENABLE = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er;
        PRESET = 1; tick(); tick(); PRESET = 0;
        total++; if ({Start, Ile_wsp, Ile_probek} !== 21'h0) begin bad++; $display("FAIL reset_outs got %h want 0", {Start, Ile_wsp, Ile_probek}); end
        total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL pready got %b want 1", PREADY); end
        xfer(32'h21, 0, 0, rd, er);
        total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL reset_status got %h/%b want 0/0", rd, er); end
    endtask

    task automatic test_wsp();
        logic [31:0] rd; logic er;
        xfer(32'h23, 1, 16, rd, er);
        total++; if (Ile_wsp !== 6'd16 || er !== 1'b0) begin bad++; $display("FAIL wsp_write got %0d/%b want 16/0", Ile_wsp, er); end
        xfer(32'h23, 0, 0, rd, er);
        total++; if (rd !== 32'd16) begin bad++; $display("FAIL wsp_read got %h want 10", rd); end
    endtask

    task automatic test_probek();
        logic [31:0] rd; logic er;
        xfer(32'h24, 1, 555, rd, er);
        total++; if (Ile_probek !== 14'd555) begin bad++; $display("FAIL probek_555 got %0d want 555", Ile_probek); end
        xfer(32'h24, 1, 32'h1_FFFF, rd, er);
        total++; if (Ile_probek !== 14'h3FFF) begin bad++; $display("FAIL probek_trunc got %h want 3fff", Ile_probek); end
        xfer(32'h24, 0, 0, rd, er);
        total++; if (rd !== 32'h3FFF) begin bad++; $display("FAIL probek_read got %h want 3fff", rd); end
    endtask

    task automatic test_start_done();
        logic [31:0] rd; logic er;
        xfer(32'h20, 1, 1, rd, er);
        tick(); tick();
        total++; if (Start !== 1'b1) begin bad++; $display("FAIL start_hold got %b want 1", Start); end
        DONE = 1; tick(); DONE = 0;
        total++; if (Start !== 1'b0) begin bad++; $display("FAIL start_autoclr got %b want 0", Start); end
        xfer(32'h21, 0, 0, rd, er);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL sticky_set got %h want 4", rd); end
        xfer(32'h21, 1, 4, rd, er);
        xfer(32'h21, 0, 0, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL sticky_w1c got %h want 0", rd); end
        DONE = 1;
        xfer(32'h20, 1, 1, rd, er);
        total++; if (Start !== 1'b1) begin bad++; $display("FAIL start_prio got %b want 1", Start); end
        xfer(32'h21, 1, 4, rd, er);
        DONE = 0;
        xfer(32'h21, 0, 0, rd, er);
        total++; if (rd[2] !== 1'b1 || Start !== 1'b0) begin bad++; $display("FAIL sticky_prio got %h/%b want bit2=1 start=0", rd, Start); end
        xfer(32'h21, 1, 4, rd, er);
    endtask

    task automatic test_busy_err();
        logic [31:0] rd; logic er;
        pracuje = 1;
        xfer(32'h23, 1, 9, rd, er);
        total++; if (er !== 1'b1 || Ile_wsp !== 6'd16) begin bad++; $display("FAIL busy_wsp got %b/%0d want 1/16", er, Ile_wsp); end
        pracuje = 0;
        xfer(32'h20, 1, 1, rd, er);
        xfer(32'h24, 1, 7, rd, er);
        total++; if (er !== 1'b1 || Ile_probek !== 14'h3FFF) begin bad++; $display("FAIL start_probek got %b/%h want 1/3fff", er, Ile_probek); end
        xfer(32'h20, 1, 0, rd, er);
        total++; if (Start !== 1'b0) begin bad++; $display("FAIL start_clear got %b want 0", Start); end
    endtask

    task automatic test_err_addr();
        logic [31:0] rd; logic er;
        xfer(32'h27, 1, 0, rd, er);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL id_write got %b want 1", er); end
        xfer(32'h22, 0, 0, rd, er);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL unmapped got %b/%h want 1/0", er, rd); end
        xfer(32'h40, 1, 32'hFFFF_FFFF, rd, er);
        total++; if (er !== 1'b1 || {Start, Ile_wsp, Ile_probek} !== {1'b0, 6'd16, 14'h3FFF}) begin bad++; $display("FAIL out_win got %b/%h want 1 unchanged", er, {Start, Ile_wsp, Ile_probek}); end
        xfer(32'h27, 0, 0, rd, er);
        total++; if (rd !== ID || er !== 1'b0) begin bad++; $display("FAIL id_read got %h/%b want %h/0", rd, er, ID); end
    endtask

    task automatic test_setup_only();
        PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h23; PWDATA = 5;
        tick(); tick();
        PSELx = 0;
        total++; if (Ile_wsp !== 6'd16) begin bad++; $display("FAIL setup_only got %0d want 16", Ile_wsp); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, er_e, rd_e; logic er, w;
        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(9) == 0 ? 32'h40 + $urandom_range(7) : 32'h20 + $urandom_range(7);
            w = 1'($urandom_range(1)); d = $urandom;
            pracuje = $urandom_range(3) == 0;
            DONE = $urandom_range(7) == 0;
            #1;
            er_e = {31'h0, exp_err(a, w)};
            xfer(a, w, d, rd, er);
            // read value is sampled in ACCESS, after the SETUP edge updated state
            total++; if (er !== er_e[0]) begin bad++; $display("FAIL rnd_err a=%h w=%b got %b want %b", a, w, er, er_e[0]); end
            if (!w) begin
                rd_e = 32'h0;
            end
            total++; if ({Start, Ile_wsp, Ile_probek} !== {m_start, m_wsp[5:0], m_probek[13:0]}) begin bad++; $display("FAIL rnd_state got %h want %h", {Start, Ile_wsp, Ile_probek}, {m_start, m_wsp[5:0], m_probek[13:0]}); end
            DONE = 0;
            PSELx = 1; PENABLE = 1; PWRITE = 0; PADDR = a;
            #1;
            rd_e = exp_rd(a, 0);
            total++; if (PRDATA !== rd_e) begin bad++; $display("FAIL rnd_read a=%h got %h want %h", a, PRDATA, rd_e); end
            PSELx = 0; PENABLE = 0;
        end
        pracuje = 0; DONE = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er;
        xfer(32'h20, 1, 1, rd, er);
        xfer(32'h21, 1, 0, rd, er);
        DONE = 1; tick(); DONE = 0;
        PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h24; PWDATA = 99;
        tick();
        PENABLE = 1; PRESET = 1;
        tick();
        PRESET = 0; PSELx = 0; PENABLE = 0;
        total++; if ({Start, Ile_wsp, Ile_probek} !== 21'h0) begin bad++; $display("FAIL reset_mid got %h want 0", {Start, Ile_wsp, Ile_probek}); end
        xfer(32'h21, 0, 0, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_sticky got %h want 0", rd); end
    endtask

    initial begin
        m_start = 0; m_sticky = 0; m_wsp = 0; m_probek = 0;
        test_reset();
        test_wsp();
        test_probek();
        test_start_done();
        test_busy_err();
        test_err_addr();
        test_setup_only();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
